// File: rtl/key_onehot_debounce.sv
// key_onehot_debounce: synchronizes and debounces four keys into a one-hot code with valid/multi flags and a press strobe.
// Define KEY_LATCH_EN to hold the last single-key code while no key (or several keys) are pressed.
module key_onehot_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    output logic [3:0] onehot,
    output logic       valid,
    output logic       multi,
    output logic       press_pulse
);
    logic [3:0] s1, s2, stable;
    logic [CNT_W-1:0] cnt [4];
    logic [3:0] nxt_onehot;
    logic nxt_valid, one, many;

    always_comb begin
        // clearing the lowest set bit leaves something only when two or more bits are set
        many = |(stable & (stable - 4'd1));
        one = (stable != 4'd0) && !many;
`ifdef KEY_LATCH_EN
        nxt_onehot = one ? stable : onehot;
        nxt_valid = one | valid;
`else
        nxt_onehot = one ? stable : 4'd0;
        nxt_valid = one;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            stable <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            onehot <= '0;
            valid <= 1'b0;
            multi <= 1'b0;
            press_pulse <= 1'b0;
        end else begin
            s1 <= key_raw;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    stable[i] <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            onehot <= nxt_onehot;
            valid <= nxt_valid;
            multi <= many;
            press_pulse <= (nxt_onehot != 4'd0) && (nxt_onehot != onehot);
        end
    end
endmodule

// File: tb/tb_key_onehot_debounce.sv
// tb_key_onehot_debounce: directed stimulus pushes per-cycle expected outputs into a queue; a negedge monitor pops and compares.
module tb_key_onehot_debounce;
`ifdef KEY_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    typedef struct packed {
        int         c;
        logic [6:0] o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] key_raw;
    logic [3:0] onehot;
    logic valid, multi, press_pulse;

    int cyc = 0;
    int tests = 0;
    int errors = 0;
    exp_t q[$];
    exp_t e;
    logic [5:0] cur;

    key_onehot_debounce #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .onehot(onehot),
        .valid(valid),
        .multi(multi),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.c < cyc) begin
                errors++;
                $display("FAIL missed_check cycle %0d (now %0d)", e.c, cyc);
            end else if ({onehot, valid, multi, press_pulse} !== e.o) begin
                errors++;
                $display("FAIL outputs cycle %0d: got oh=%b v=%b m=%b p=%b, expected oh=%b v=%b m=%b p=%b",
                         cyc, onehot, valid, multi, press_pulse, e.o[6:3], e.o[2], e.o[1], e.o[0]);
            end
        end
    end

    task automatic push(input int c, input logic [6:0] o);
        q.push_back('{c: c, o: o});
    endtask

    task automatic push_range(input int a, input int b, input logic [6:0] o);
        for (int c = a; c <= b; c++) push(c, o);
    endtask

    // new key level captured at E0, outputs change at E0+6
    task automatic step(input logic [3:0] k, input logic [3:0] oh, input logic v, input logic m, input logic p);
        int e0;
        key_raw = k;
        e0 = cyc + 1;
        push_range(e0, e0 + 5, {cur, 1'b0});
        push(e0 + 6, {oh, v, m, p});
        push_range(e0 + 7, e0 + 9, {oh, v, m, 1'b0});
        cur = {oh, v, m};
        repeat (10) @(negedge clk);
    endtask

    initial begin
        int e0;
        rst = 1'b1;
        key_raw = 4'b1111;
        push_range(1, 5, 7'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        push_range(6, 11, 7'b0);
        push_range(12, 15, 7'b0000_010);
        cur = 6'b0000_01;
        repeat (10) @(negedge clk);

        step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
        step(4'b0000, LATCH ? 4'b0010 : 4'b0000, LATCH, 1'b0, 1'b0);

        // three-cycle glitch falls one short of the debounce window
        e0 = cyc + 1;
        push_range(e0, e0 + 11, {cur, 1'b0});
        key_raw = 4'b0100;
        repeat (3) @(negedge clk);
        key_raw = 4'b0000;
        repeat (9) @(negedge clk);

        push_range(cyc + 1, cyc + 12, {cur, 1'b0});
        for (int i = 0; i < 3; i++) begin
            key_raw = 4'b0001;
            repeat (2) @(negedge clk);
            key_raw = 4'b0000;
            repeat (2) @(negedge clk);
        end
        step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1);

        step(4'b0000, LATCH ? 4'b0001 : 4'b0000, LATCH, 1'b0, 1'b0);
        step(4'b0011, LATCH ? 4'b0001 : 4'b0000, LATCH, 1'b1, 1'b0);
        step(4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1);
        step(4'b0000, LATCH ? 4'b0010 : 4'b0000, LATCH, 1'b0, 1'b0);

        // reset lands mid-count; key must re-qualify from scratch
        key_raw = 4'b1000;
        e0 = cyc + 1;
        push_range(e0, e0 + 2, {cur, 1'b0});
        push_range(e0 + 3, e0 + 9, 7'b0);
        push(e0 + 10, 7'b1000_101);
        push_range(e0 + 11, e0 + 13, 7'b1000_100);
        cur = 6'b1000_10;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        step(4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1);
        step(4'b0000, LATCH ? 4'b0100 : 4'b0000, LATCH, 1'b0, 1'b0);
        step(4'b0100, 4'b0100, 1'b1, 1'b0, !LATCH);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            tests++;
            errors++;
            $display("FAIL drain: %0d checks pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
